// File: rtl/cpu_pkg.sv
// Shared definitions for the microprogrammed CPU: microword layout,
// branch-select encoding, sequencer state encoding and field widths.
package cpu_pkg;

  localparam int UPC_W   = 8;
  localparam int BRSEL_W = 3;
  localparam int CTRL_W  = 11;
  localparam int OPC_W   = 6;
  localparam int MWORD_W = UPC_W + BRSEL_W + CTRL_W;

  // Next-address decision carried in every microword.
  typedef enum logic [BRSEL_W-1:0] {
    BR_SEQ   = 3'd0,  // upc + 1
    BR_JMP   = 3'd1,  // next_addr
    BR_MAP   = 3'd2,  // mapping ROM dispatch
    BR_JZ    = 3'd3,  // cond_z ? next_addr : upc + 1
    BR_CALL  = 3'd4,  // push upc + 1, goto next_addr
    BR_RET   = 3'd5,  // pop into upc
    BR_WAIT  = 3'd6,  // hold until ext_rdy, then upc + 1
    BR_FETCH = 3'd7   // opcode handshake, then goto next_addr
  } br_sel_e;

  // Sequencer states; the top keeps legacy localparam copies of these codes.
  typedef enum logic [1:0] {
    US_IDLE  = 2'd0,
    US_RUN   = 2'd1,
    US_STALL = 2'd2,
    US_FAULT = 2'd3
  } useq_state_e;

  // Microword layout, MSB to LSB.
  typedef struct packed {
    logic [UPC_W-1:0]  next_addr;
    br_sel_e           br_sel;
    logic [CTRL_W-1:0] ctrl;
  } MPROM_ENCODE;

  // Reinterpret a raw ROM word as a structured microword.
  function automatic MPROM_ENCODE decode_mword(input logic [MWORD_W-1:0] raw);
    return MPROM_ENCODE'(raw);
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for microcode CALL/RET. The pointer counts stored
// entries (0..DEPTH); the top entry is always readable on dout.
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      ptr;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    top_idx;

  assign full    = (ptr == (PW+1)'(DEPTH));
  assign empty   = (ptr == '0);
  assign wr_idx  = ptr[PW-1:0];
  // When full the low pointer bits wrap to 0, so top_idx lands on DEPTH-1.
  assign top_idx = ptr[PW-1:0] - PW'(1);
  assign dout    = mem[top_idx];

  // Entry count: grows on push, shrinks on pop; overflow/underflow refused.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (!reset_n) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - (PW+1)'(1);
    end
  end

  // Storage write on push.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; the pointer alone defines which
    // entries are meaningful, and leaving the array unreset keeps it as plain RAM.
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microprogram sequencer: owns the micro-PC, addresses the microprogram and
// mapping ROMs, decodes each microword into a next-address decision and a
// gated control word, and handles opcode fetch, call/return and wait stalls.
module useq_ctrl
  import cpu_pkg::*;
#(
  parameter int               STACK_DEPTH = 4,
  parameter logic [UPC_W-1:0] UPC_RESET   = 8'h00
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                cond_z,
  input  logic                ext_rdy,
  output logic [UPC_W-1:0]    mprom_addr,
  input  logic [MWORD_W-1:0]  mprom_dout,
  input  logic                mprom_err,
  output logic [OPC_W-1:0]    map_addr,
  input  logic [UPC_W-1:0]    map_dout,
  input  logic                map_err,
  output logic [CTRL_W-1:0]   ctrl,
  output logic                busy,
  output logic                fault
);

  localparam logic [1:0] S_IDLE  = 2'(US_IDLE);
  localparam logic [1:0] S_RUN   = 2'(US_RUN);
  localparam logic [1:0] S_STALL = 2'(US_STALL);
  localparam logic [1:0] S_FAULT = 2'(US_FAULT);

  logic [1:0]       state, state_nx;
  logic [UPC_W-1:0] upc, upc_nx, upc_inc;
  logic [OPC_W-1:0] opc_q;
  MPROM_ENCODE      mw;
  logic             active;
  logic             xfer;

  logic             stk_push, stk_pop;
  logic             stk_full, stk_empty;
  logic [UPC_W-1:0] stk_dout;

  assign mw      = decode_mword(mprom_dout);
  assign upc_inc = upc + UPC_W'(1);  // wraps FF -> 00 by construction
  assign active  = (state == S_RUN) || (state == S_STALL);

  // A FETCH microword offers the handshake while it is current, unless the
  // ROM flags that very word as bad (the sequencer is about to fault).
  assign instr_ready = active && (mw.br_sel == BR_FETCH) && !mprom_err;
  assign xfer        = instr_ready && instr_valid;

  assign mprom_addr = upc;
  assign map_addr   = opc_q;
  assign ctrl       = (state == S_RUN) ? mw.ctrl : '0;
  assign busy       = (state != S_IDLE);
  assign fault      = (state == S_FAULT);

  useq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (UPC_W)
  ) u_stack (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (stk_push),
    .pop     (stk_pop),
    .din     (upc_inc),
    .dout    (stk_dout),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  // Next-state and next-address decision from the current microword.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    state_nx = state;
    upc_nx   = upc;
    stk_push = 1'b0;
    stk_pop  = 1'b0;

    case (state)
      S_IDLE: state_nx = S_RUN;

      S_RUN, S_STALL: begin
        if (mprom_err) begin
          state_nx = S_FAULT;
        end else begin
          // STALL is only ever entered on WAIT or FETCH with upc held, so the
          // same microword is re-evaluated each stalled cycle.
          case (mw.br_sel)
            BR_SEQ: begin
              upc_nx   = upc_inc;
              state_nx = S_RUN;
            end
            BR_JMP: begin
              upc_nx   = mw.next_addr;
              state_nx = S_RUN;
            end
            BR_MAP: begin
              if (map_err) begin
                state_nx = S_FAULT;
              end else begin
                upc_nx   = map_dout;
                state_nx = S_RUN;
              end
            end
            BR_JZ: begin
              upc_nx   = cond_z ? mw.next_addr : upc_inc;
              state_nx = S_RUN;
            end
            BR_CALL: begin
              if (stk_full) begin
                state_nx = S_FAULT;
              end else begin
                stk_push = 1'b1;
                upc_nx   = mw.next_addr;
                state_nx = S_RUN;
              end
            end
            BR_RET: begin
              if (stk_empty) begin
                state_nx = S_FAULT;
              end else begin
                stk_pop  = 1'b1;
                upc_nx   = stk_dout;
                state_nx = S_RUN;
              end
            end
            BR_WAIT: begin
              if (ext_rdy) begin
                upc_nx   = upc_inc;
                state_nx = S_RUN;
              end else begin
                state_nx = S_STALL;
              end
            end
            BR_FETCH: begin
              if (instr_valid) begin
                upc_nx   = mw.next_addr;
                state_nx = S_RUN;
              end else begin
                state_nx = S_STALL;
              end
            end
          endcase
        end
      end

      // FAULT holds everything until reset_n.
      default: ;
    endcase
  end

  // State and micro-PC registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      upc   <= UPC_RESET;
    end else begin
      state <= state_nx;
      upc   <= upc_nx;
    end
  end

  // Opcode latch feeding the mapping ROM, loaded on each accepted transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opc_q <= '0;
    end else if (xfer) begin
      opc_q <= opcode;
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Directed bench for useq_ctrl. The bench plays both ROMs; each driven cycle
// pushes its hand-computed expected outputs into a scoreboard queue, and a
// monitor pops and compares on the falling edge.
module tb_useq_ctrl;
  import cpu_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [OPC_W-1:0]  opcode = '0;
  logic              cond_z = 1'b0;
  logic              ext_rdy = 1'b0;
  logic [UPC_W-1:0]  mprom_addr;
  logic [MWORD_W-1:0] mprom_dout;
  logic              mprom_err = 1'b0;
  logic [OPC_W-1:0]  map_addr;
  logic [UPC_W-1:0]  map_dout;
  logic              map_err = 1'b0;
  logic [CTRL_W-1:0] ctrl;
  logic              busy;
  logic              fault;

  logic [MWORD_W-1:0] rom    [256];
  logic [UPC_W-1:0]   maptab [64];

  assign mprom_dout = rom[mprom_addr];
  assign map_dout   = maptab[map_addr];

  always #5 clock = ~clock;

  useq_ctrl #(
    .STACK_DEPTH (4),
    .UPC_RESET   (8'h00)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .cond_z      (cond_z),
    .ext_rdy     (ext_rdy),
    .mprom_addr  (mprom_addr),
    .mprom_dout  (mprom_dout),
    .mprom_err   (mprom_err),
    .map_addr    (map_addr),
    .map_dout    (map_dout),
    .map_err     (map_err),
    .ctrl        (ctrl),
    .busy        (busy),
    .fault       (fault)
  );

  typedef struct {
    logic [7:0]  upc;
    logic [10:0] ctrl;
    logic        ready;
    logic        busy;
    logic        fault;
    logic [5:0]  map;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [21:0] mw(input logic [7:0] na, input br_sel_e bs,
                                     input logic [10:0] c);
    return {na, bs, c};
  endfunction

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got upc=%h ctrl=%h rdy=%b busy=%b fault=%b map=%h, want upc=%h ctrl=%h rdy=%b busy=%b fault=%b map=%h",
               name, got[27:20], got[19:9], got[8], got[7], got[6], got[5:0],
               want[27:20], want[19:9], want[8], want[7], want[6], want[5:0]);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, {mprom_addr, ctrl, instr_ready, busy, fault, map_addr},
            {e.upc, e.ctrl, e.ready, e.busy, e.fault, e.map});
    end
  end

  // Issue one cycle: record its expected outputs, then advance to just after
  // the next rising edge where the following stimulus is applied.
  task automatic cyc(input logic [7:0] u, input logic [10:0] c, input logic r,
                     input logic b, input logic f, input logic [5:0] m,
                     input string n);
    exp_t x;
    x.upc = u; x.ctrl = c; x.ready = r; x.busy = b; x.fault = f; x.map = m; x.name = n;
    sb_q.push_back(x);
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 64; i++) maptab[i] = '0;

    // Main program: SEQ run, FETCH/MAP dispatch, CALL/RET, JZ, wrap.
    rom[8'h00] = mw(8'h00, BR_SEQ,   11'h001);
    rom[8'h01] = mw(8'h00, BR_SEQ,   11'h002);
    rom[8'h02] = mw(8'h00, BR_SEQ,   11'h004);
    rom[8'h03] = mw(8'h05, BR_JMP,   11'h008);
    rom[8'h05] = mw(8'h10, BR_FETCH, 11'h010);
    rom[8'h10] = mw(8'h00, BR_MAP,   11'h020);
    rom[8'h40] = mw(8'h20, BR_JMP,   11'h040);
    rom[8'h20] = mw(8'h80, BR_CALL,  11'h080);
    rom[8'h80] = mw(8'h00, BR_RET,   11'h100);
    rom[8'h21] = mw(8'h30, BR_JMP,   11'h200);
    rom[8'h30] = mw(8'h50, BR_JZ,    11'h400);
    rom[8'h31] = mw(8'h30, BR_JMP,   11'h003);
    rom[8'h50] = mw(8'hFF, BR_JMP,   11'h005);
    rom[8'hFF] = mw(8'h00, BR_SEQ,   11'h006);
    maptab[6'h2A] = 8'h40;

    @(posedge clock);
    #1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "reset");
    reset_n = 1'b1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "idle");
    cyc(8'h00, 11'h001, 0, 1, 0, 6'h00, "seq_00");
    cyc(8'h01, 11'h002, 0, 1, 0, 6'h00, "seq_01");
    cyc(8'h02, 11'h004, 0, 1, 0, 6'h00, "seq_02");
    cyc(8'h03, 11'h008, 0, 1, 0, 6'h00, "jmp_03");
    cyc(8'h05, 11'h010, 1, 1, 0, 6'h00, "fetch_run");
    cyc(8'h05, 11'h000, 1, 1, 0, 6'h00, "fetch_stall1");
    cyc(8'h05, 11'h000, 1, 1, 0, 6'h00, "fetch_stall2");
    instr_valid = 1'b1; opcode = 6'h2A;
    cyc(8'h05, 11'h000, 1, 1, 0, 6'h00, "fetch_xfer");
    instr_valid = 1'b0; opcode = 6'h00;
    cyc(8'h10, 11'h020, 0, 1, 0, 6'h2A, "map_10");
    cyc(8'h40, 11'h040, 0, 1, 0, 6'h2A, "map_target");
    cyc(8'h20, 11'h080, 0, 1, 0, 6'h2A, "call_20");
    cyc(8'h80, 11'h100, 0, 1, 0, 6'h2A, "ret_80");
    cyc(8'h21, 11'h200, 0, 1, 0, 6'h2A, "ret_target");
    cyc(8'h30, 11'h400, 0, 1, 0, 6'h2A, "jz_not_taken");
    cyc(8'h31, 11'h003, 0, 1, 0, 6'h2A, "jz_fallthru");
    cond_z = 1'b1;
    cyc(8'h30, 11'h400, 0, 1, 0, 6'h2A, "jz_taken");
    cond_z = 1'b0;
    cyc(8'h50, 11'h005, 0, 1, 0, 6'h2A, "jz_target");
    cyc(8'hFF, 11'h006, 0, 1, 0, 6'h2A, "seq_ff");
    cyc(8'h00, 11'h001, 0, 1, 0, 6'h2A, "wrap_00");

    // Five nested CALLs against a 4-deep stack.
    reset_n = 1'b0;
    rom[8'h00] = mw(8'h60, BR_CALL, 11'h011);
    rom[8'h60] = mw(8'h61, BR_CALL, 11'h012);
    rom[8'h61] = mw(8'h62, BR_CALL, 11'h013);
    rom[8'h62] = mw(8'h63, BR_CALL, 11'h014);
    rom[8'h63] = mw(8'h64, BR_CALL, 11'h015);
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "reset2");
    reset_n = 1'b1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "idle2");
    cyc(8'h00, 11'h011, 0, 1, 0, 6'h00, "call1");
    cyc(8'h60, 11'h012, 0, 1, 0, 6'h00, "call2");
    cyc(8'h61, 11'h013, 0, 1, 0, 6'h00, "call3");
    cyc(8'h62, 11'h014, 0, 1, 0, 6'h00, "call4");
    cyc(8'h63, 11'h015, 0, 1, 0, 6'h00, "call5");
    cyc(8'h63, 11'h000, 0, 1, 1, 6'h00, "overflow_fault");
    ext_rdy = 1'b1; instr_valid = 1'b1;
    cyc(8'h63, 11'h000, 0, 1, 1, 6'h00, "fault_frozen1");
    cyc(8'h63, 11'h000, 0, 1, 1, 6'h00, "fault_frozen2");
    ext_rdy = 1'b0; instr_valid = 1'b0;

    // WAIT stall interrupted by an asynchronous reset.
    reset_n = 1'b0;
    rom[8'h00] = mw(8'h12, BR_JMP,  11'h021);
    rom[8'h12] = mw(8'h00, BR_WAIT, 11'h022);
    rom[8'h13] = mw(8'h00, BR_RET,  11'h023);
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "reset3");
    reset_n = 1'b1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "idle3");
    cyc(8'h00, 11'h021, 0, 1, 0, 6'h00, "jmp_to_wait");
    cyc(8'h12, 11'h022, 0, 1, 0, 6'h00, "wait_run");
    cyc(8'h12, 11'h000, 0, 1, 0, 6'h00, "wait_stall");
    reset_n = 1'b0;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "async_reset");

    // WAIT resume, then RET on an empty stack.
    reset_n = 1'b1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "idle4");
    cyc(8'h00, 11'h021, 0, 1, 0, 6'h00, "jmp_to_wait4");
    cyc(8'h12, 11'h022, 0, 1, 0, 6'h00, "wait_run4");
    ext_rdy = 1'b1;
    cyc(8'h12, 11'h000, 0, 1, 0, 6'h00, "wait_release");
    ext_rdy = 1'b0;
    cyc(8'h13, 11'h023, 0, 1, 0, 6'h00, "ret_empty");
    cyc(8'h13, 11'h000, 0, 1, 1, 6'h00, "underflow_fault");

    // MAP with map_err.
    reset_n = 1'b0;
    rom[8'h00] = mw(8'h00, BR_MAP, 11'h031);
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "reset5");
    reset_n = 1'b1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "idle5");
    map_err = 1'b1;
    cyc(8'h00, 11'h031, 0, 1, 0, 6'h00, "map_err_word");
    map_err = 1'b0;
    cyc(8'h00, 11'h000, 0, 1, 1, 6'h00, "map_err_fault");

    // mprom_err while running.
    reset_n = 1'b0;
    rom[8'h00] = mw(8'h00, BR_SEQ, 11'h041);
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "reset6");
    reset_n = 1'b1;
    cyc(8'h00, 11'h000, 0, 0, 0, 6'h00, "idle6");
    cyc(8'h00, 11'h041, 0, 1, 0, 6'h00, "seq_before_err");
    mprom_err = 1'b1;
    cyc(8'h01, 11'h002, 0, 1, 0, 6'h00, "mprom_err_word");
    mprom_err = 1'b0;
    cyc(8'h01, 11'h000, 0, 1, 1, 6'h00, "mprom_err_fault");

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/useq_ctrl.md
# useq_ctrl

Microprogram sequencer for the simplified microprogrammed CPU: owns the micro-PC, addresses the microprogram ROM (`mprom`) and the mapping ROM (`maprom`), and decodes each 22-bit microword into a next-address decision and a control-word output. Sits between the instruction register and the datapath. It fetches opcodes through a valid/ready handshake, dispatches through the mapping ROM, and supports subroutine call/return and external-wait stalls.

## Interface
- `STACK_DEPTH`, 4: return-address stack entries (power of 2, ≥2)
- `UPC_RESET`, 8'h00: micro-PC value after reset
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- `instr_valid`  in  1  opcode available from instruction register
- `instr_ready`  out  1  sequencer accepts opcode this cycle
- `opcode`  in  6  opcode to dispatch
- `cond_z`  in  1  datapath zero flag for conditional branch
- `ext_rdy`  in  1  external resource ready (ends WAIT)
- `mprom_addr`  out  8  micro-PC to `mprom`
- `mprom_dout`  in  22  microword (`MPROM_ENCODE`)
- `mprom_err`  in  1  `mprom` addr_error
- `map_addr`  out  6  latched opcode to `maprom`
- `map_dout`  in  8  dispatch target
- `map_err`  in  1  `maprom` addr_error
- `ctrl`  out  11  datapath control word, zero when not executing
- `busy`  out  1  state ≠ IDLE
- `fault`  out  1  sticky error

## Operation
- Microword fields (MSB→LSB): `next_addr[7:0]`, `br_sel[2:0]`, `ctrl[10:0]`.
- `br_sel` decode: SEQ=0 (upc+1), JMP=1 (next_addr), MAP=2 (map_dout), JZ=3 (cond_z ? next_addr : upc+1), CALL=4 (push upc+1, goto next_addr), RET=5 (pop → upc), WAIT=6 (hold until ext_rdy, then upc+1), FETCH=7 (opcode handshake, then goto next_addr).
- States: IDLE, RUN, STALL, FAULT.
- IDLE: reset exit state. Moves to RUN on the first clock after reset deassertion. `ctrl`=0.
- RUN: `ctrl` = microword ctrl. upc updates every cycle per `br_sel`.
  - WAIT with ext_rdy=0 goes to STALL.
  - FETCH with instr_valid=0 goes to STALL.
- STALL: upc held. `ctrl` = 0.
  - Resumes to RUN on the cycle ext_rdy=1 (WAIT) or instr_valid=1 (FETCH), applying that microword's next address.
- FETCH: `instr_ready` = 1 in the cycle that the FETCH microword is current (RUN or STALL). A transfer occurs when instr_valid && instr_ready, and the opcode is latched into `map_addr`. `map_addr` resets to 0.
- upc arithmetic: 8-bit, upc+1 wraps 8'hFF→8'h00 with no error.
- Stack:
  - CALL when full (STACK_DEPTH entries) → FAULT.
  - RET when empty → FAULT.
  - CALL stores upc+1 (wrapped).
- Errors: mprom_err in RUN/STALL, map_err during a MAP microword, or a stack fault moves to FAULT.
  - FAULT: `ctrl`=0, `fault`=1, `instr_ready`=0, upc frozen.
  - FAULT exits only via reset_n.

## Timing
- Reset values: upc=UPC_RESET, state=IDLE, stack pointer=0, `ctrl`=0, `instr_ready`=0, `busy`=0, `fault`=0, `map_addr`=0.
- `mprom_addr` is the upc register, driven directly. ROMs are combinational, so microword and decode resolve in the same cycle.
- `ctrl` is combinational from the current microword gated by state; it has 0-cycle latency from upc.
- Throughput: one microword per cycle in RUN.
- MAP dispatch uses the `map_addr` latched at the most recent FETCH. The dispatch target is upc on the next edge.
- FETCH with a simultaneous valid: the transfer happens and upc = next_addr on the same edge, with no stall cycle.
- reset_n asserted mid-operation: all state clears immediately and asynchronously. A pending handshake is dropped and `instr_ready` falls at once.

## Structure
- Shared package `cpu_pkg`: `MPROM_ENCODE` packed struct, `br_sel_e` enum, `useq_state_e` enum, field widths.
- One sub-module `useq_stack`:
  - Ports: push, pop, din[7:0], dout[7:0], full, empty.
  - LIFO with asynchronous active-low reset on its pointer.
- Top-level `useq_ctrl`: state FSM, upc register, next-address mux, opcode latch, error detection.

## Test plan
- Reset, then SEQ microwords at 00–02 → `mprom_addr` 00,01,02,03 on successive cycles; `ctrl` follows the microword ctrl fields.
- FETCH at upc 05 with next_addr 10, instr_valid low 3 cycles then high with opcode 6'h2A:
  - `instr_ready` is high 4 cycles.
  - `ctrl`=0 for 3 cycles.
  - upc=10 after the transfer.
  - MAP at 10 with map_dout 8'h40 → upc=40.
- CALL 80 at upc 20, then RET at 80 → upc sequence 20,80,21. The stack returns to empty.
- Five nested CALLs with STACK_DEPTH=4 → `fault`=1 on the fifth; upc frozen and `ctrl`=0 until reset_n.
- JZ at upc 30 to 50: cond_z=1 → 50, cond_z=0 → 31. SEQ at upc FF → wraps to 00.
- WAIT at upc 12 with ext_rdy=0 for 2 cycles, and reset_n pulsed low during the stall → immediate IDLE, upc=00, `ctrl`=0, `busy`=0.
